rv32i_alu_sched: RTL and testbench

//  Shares one registered rv32i ALU between NUM_REQ requesters (e.g. pipeline EXECUTE, branch/address unit).

---
 rtl/rv32i_alu_pkg.sv | 44 ++++
 rtl/rv32i_alu_sched_arb.sv | 60 ++++++
 rtl/rv32i_alu_sched.sv | 112 +++++++++++
 tb/tb_rv32i_alu_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_alu_pkg.sv
// Shared op codes, FSM encoding and decode helper for the rv32i ALU scheduler.
package rv32i_alu_pkg;

   localparam int XLEN     = 32;
   localparam int OP_W     = 4;
   localparam int ALU_OP_N = 14;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SLT  = 4'd2,
      OP_SLTU = 4'd3,
      OP_XOR  = 4'd4,
      OP_OR   = 4'd5,
      OP_AND  = 4'd6,
      OP_SLL  = 4'd7,
      OP_SRL  = 4'd8,
      OP_SRA  = 4'd9,
      OP_EQ   = 4'd10,
      OP_NEQ  = 4'd11,
      OP_GE   = 4'd12,
      OP_GEU  = 4'd13
   } alu_op_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   function automatic logic op_illegal(input logic [OP_W-1:0] op);
      return op >= 4'd14;
   endfunction

   // Strobe bit position equals the op code; illegal codes give no strobe.
   function automatic logic [ALU_OP_N-1:0] op_to_onehot(
      input logic [OP_W-1:0] op
   );
      logic [ALU_OP_N-1:0] oh;
      oh = '0;
      if (!op_illegal(op))
         oh = ALU_OP_N'(1) << op;
      return oh;
   endfunction

endpackage

// File: rtl/rv32i_alu_sched_arb.sv
// Requester arbiter: round-robin by default, fixed lowest-index priority
// when ALU_SCHED_FIXED_PRIO_EN is defined.
module rv32i_rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

`ifdef ALU_SCHED_FIXED_PRIO_EN
   logic unused_arb;
   assign unused_arb = ^{clk, rst, advance};

   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`else
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;

   // Search starts just past the last winner so nobody starves.
   always_comb begin
      logic found;
      int   idx;
      grant = '0;
      win   = ptr;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            win        = PW'(idx);
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= PW'(N - 1);
      else if (advance)
         ptr <= win;
   end
`endif

endmodule

// File: rtl/rv32i_alu_sched.sv
// Shares one registered rv32i ALU among NUM_REQ valid/ready requesters.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority instead of round-robin.
module rv32i_alu_sched
   import rv32i_alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [4*NUM_REQ-1:0]  req_op,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  rsp_err,
   output logic                  alu_en,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic [13:0]           alu_op_oh,
   input  logic [31:0]           alu_y
);

   logic [1:0]         state;
   logic [NUM_REQ-1:0] grant_oh;
   logic               accept_ok;
   logic               accept;
   logic [ID_W-1:0]    gnt_id;
   logic [OP_W-1:0]    sel_op;
   logic [31:0]        sel_a;
   logic [31:0]        sel_b;
   logic [1:0]         tgt;
   logic [OP_W-1:0]    op_q;
   logic [ID_W-1:0]    id_q;
   logic               err_q;

   rv32i_rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant_oh)
   );

   assign accept_ok = (state == ST_IDLE)
                    | ((state == ST_RESP) & rsp_ready);
   // Held low during reset so nothing is offered while state is forced.
   assign req_ready = grant_oh & {NUM_REQ{accept_ok & ~rst}};
   assign accept    = |(req_valid & req_ready);

   always_comb begin
      gnt_id = '0;
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            gnt_id = ID_W'(i);
            sel_op = req_op[4*i +: 4];
            sel_a  = req_a[32*i +: 32];
            sel_b  = req_b[32*i +: 32];
         end
      end
   end

   assign tgt = op_illegal(sel_op) ? ST_RESP : ST_EXEC;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         op_q  <= '0;
         id_q  <= '0;
         err_q <= 1'b0;
         alu_a <= '0;
         alu_b <= '0;
      end else begin
         unique case (state)
            ST_IDLE: if (accept) state <= tgt;
            ST_EXEC: state <= ST_RESP;
            ST_RESP: begin
               if (rsp_ready)
                  state <= accept ? tgt : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
         if (accept) begin
            op_q  <= sel_op;
            id_q  <= gnt_id;
            err_q <= op_illegal(sel_op);
            // Operands only move for ops that will reach the ALU.
            if (!op_illegal(sel_op)) begin
               alu_a <= sel_a;
               alu_b <= sel_b;
            end
         end
      end
   end

   assign alu_en    = (state == ST_EXEC);
   assign alu_op_oh = alu_en ? op_to_onehot(op_q) : '0;
   assign rsp_valid = (state == ST_RESP);
   assign rsp_data  = (rsp_valid & ~err_q) ? alu_y : '0;
   assign rsp_id    = id_q;
   assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_rv32i_alu_sched.sv
// Randomized bench for rv32i_alu_sched against a transaction-level
// reference of arbitration, latency and ALU results.
module tb_rv32i_alu_sched;

   localparam int N  = 2;
   localparam int IW = 1;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } req_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [4*N-1:0]  req_op;
   logic [32*N-1:0] req_a;
   logic [32*N-1:0] req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_data;
   logic [IW-1:0] rsp_id;
   logic          rsp_err;
   logic          alu_en;
   logic [31:0]   alu_a;
   logic [31:0]   alu_b;
   logic [13:0]   alu_op_oh;
   logic [31:0]   alu_y = '0;

   int n_tests = 0;
   int n_fail  = 0;

   req_t rq [N][$];
   int   served [$];
   bit   rand_on;
   int   rr_mode;

   bit          have;
   req_t        t_req;
   int          t_id;
   int          acc_cyc;
   int          rcyc;
   int          m_ptr;
   int          cyc;
   bit          exp_en_now;

   always #5 clk = ~clk;

   rv32i_alu_sched #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_err   (rsp_err),
      .alu_en    (alu_en),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op_oh (alu_op_oh),
      .alu_y     (alu_y)
   );

   function automatic logic [31:0] ref_result(
      input logic [3:0] op, input logic [31:0] a, input logic [31:0] b
   );
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return {31'd0, $signed(a) < $signed(b)};
         4'd3:    return {31'd0, a < b};
         4'd4:    return a ^ b;
         4'd5:    return a | b;
         4'd6:    return a & b;
         4'd7:    return a << b[4:0];
         4'd8:    return a >> b[4:0];
         4'd9:    return $unsigned($signed(a) >>> b[4:0]);
         4'd10:   return {31'd0, a == b};
         4'd11:   return {31'd0, a != b};
         4'd12:   return {31'd0, $signed(a) >= $signed(b)};
         4'd13:   return {31'd0, a >= b};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] alu_ref(
      input logic [13:0] oh, input logic [31:0] a, input logic [31:0] b
   );
      if ($countones(oh) != 1) return 32'hDEAD_BEEF;
      for (int i = 0; i < 14; i++)
         if (oh[i]) return ref_result(4'(i), a, b);
      return 32'hDEAD_BEEF;
   endfunction

   // Stand-in registered ALU: result updates only on the enable pulse.
   always @(posedge clk)
      if (alu_en) alu_y <= alu_ref(alu_op_oh, alu_a, alu_b);

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 4))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   function automatic req_t mk(input int op, input logic [31:0] a,
                               input logic [31:0] b);
      req_t r;
      r.op = 4'(op);
      r.a  = a;
      r.b  = b;
      return r;
   endfunction

   function automatic int pick_winner(input logic [N-1:0] v);
`ifdef ALU_SCHED_FIXED_PRIO_EN
      for (int k = 0; k < N; k++)
         if (v[k]) return k;
`else
      for (int k = 1; k <= N; k++)
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
      return -1;
   endfunction

   task automatic model_reset();
      have  = 1'b0;
      m_ptr = N - 1;
      exp_en_now = 1'b0;
      for (int i = 0; i < N; i++) rq[i].delete();
   endtask

   task automatic step();
      bit            exp_rv;
      bit            ok;
      int            w;
      logic [N-1:0]  exp_rdy;
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++)
         if (rand_on && rq[i].size() == 0 && $urandom_range(0, 3) != 0)
            rq[i].push_back(mk($urandom_range(0, 15), pick_val(), pick_val()));
      for (int i = 0; i < N; i++) begin
         req_valid[i] = (rq[i].size() > 0);
         if (rq[i].size() > 0) begin
            req_op[4*i +: 4]  = rq[i][0].op;
            req_a[32*i +: 32] = rq[i][0].a;
            req_b[32*i +: 32] = rq[i][0].b;
         end
      end
      rsp_ready = (rr_mode == 0) ? 1'b1 :
                  (rr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      #4;
      exp_rv = have && (cyc >= rcyc);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
         check("rsp_data", rsp_data,
               ref_result(t_req.op, t_req.a, t_req.b));
         check("rsp_id", 32'(rsp_id), 32'(t_id));
         check("rsp_err", 32'(rsp_err), 32'(t_req.op >= 4'd14));
      end
      exp_en_now = have && (t_req.op < 4'd14) && (cyc == acc_cyc + 1);
      check("alu_en", 32'(alu_en), 32'(exp_en_now));
      if (exp_en_now) begin
         check("alu_op_oh", 32'(alu_op_oh), 32'(1) << t_req.op);
         check("alu_a", alu_a, t_req.a);
         check("alu_b", alu_b, t_req.b);
      end else begin
         check("alu_op_idle", 32'(alu_op_oh), 32'd0);
      end
      ok = !have || (exp_rv && rsp_ready);
      w  = ok ? pick_winner(req_valid) : -1;
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (exp_rv && rsp_ready) have = 1'b0;
      if (w >= 0) begin
         have    = 1'b1;
         t_req   = rq[w].pop_front();
         t_id    = w;
         acc_cyc = cyc;
         rcyc    = (t_req.op >= 4'd14) ? cyc + 1 : cyc + 2;
`ifndef ALU_SCHED_FIXED_PRIO_EN
         m_ptr   = w;
`endif
         served.push_back(w);
      end
   endtask

   initial begin
      bit seen;
      rst       = 1'b1;
      req_valid = '1;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      rand_on   = 1'b0;
      rr_mode   = 0;
      cyc       = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_alu_en", 32'(alu_en), 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // Contention straight after reset: requester 0 first.
      served.delete();
      for (int i = 0; i < N; i++)
         repeat (2) rq[i].push_back(mk(1, pick_val(), pick_val()));
      repeat (12) step();
      check("served_n", 32'(served.size()), 32'd4);
      if (served.size() >= 4) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
         check("order0", 32'(served[0]), 32'd0);
         check("order1", 32'(served[1]), 32'd0);
         check("order2", 32'(served[2]), 32'd1);
         check("order3", 32'(served[3]), 32'd1);
`else
         check("order0", 32'(served[0]), 32'd0);
         check("order1", 32'(served[1]), 32'd1);
         check("order2", 32'(served[2]), 32'd0);
         check("order3", 32'(served[3]), 32'd1);
`endif
      end

      // Directed ops, including an illegal code from requester 1.
      rq[0].push_back(mk(0, 32'd5, 32'd7));
      repeat (4) step();
      rq[0].push_back(mk(9, 32'h8000_0000, 32'd4));
      rq[0].push_back(mk(2, 32'hFFFF_FFFF, 32'd1));
      rq[0].push_back(mk(13, 32'd1, 32'hFFFF_FFFF));
      rq[1].push_back(mk(15, 32'd3, 32'd4));
      repeat (12) step();

      // Response backpressure with both requesters waiting.
      rq[0].push_back(mk(0, 32'd10, 32'd20));
      rq[1].push_back(mk(4, 32'hF0F0, 32'h0FF0));
      repeat (2) step();
      rr_mode = 2;
      repeat (6) step();
      rr_mode = 0;
      repeat (8) step();

      rand_on = 1'b1;
      rr_mode = 1;
      repeat (3000) step();
      rand_on = 1'b0;
      rr_mode = 0;
      repeat (12) step();

      // Reset while the ALU pulse is active.
      rq[0].push_back(mk(0, 32'd1, 32'd2));
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (exp_en_now) begin
            seen = 1'b1;
            break;
         end
      end
      check("exec_seen", 32'(seen), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_alu_en", 32'(alu_en), 32'd0);
      check("mid_op_oh", 32'(alu_op_oh), 32'd0);
      check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rsp_data", rsp_data, 32'd0);
      check("mid_alu_a", alu_a, 32'd0);
      check("mid_alu_b", alu_b, 32'd0);
      check("mid_rsp_id", 32'(rsp_id), 32'd0);
      check("mid_req_ready", 32'(req_ready), 32'd0);
      model_reset();
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      served.delete();
      rq[0].push_back(mk(1, 32'd9, 32'd4));
      rq[1].push_back(mk(1, 32'd8, 32'd3));
      repeat (8) step();
      check("post_rst_n", 32'(served.size()), 32'd2);
      if (served.size() >= 1)
         check("post_rst_first", 32'(served[0]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
